bus_handshake_monitor: RTL

- Synthesizable, parametrised run-time monitor for the dValid/dAck/data transfer protocol.
- Instantiates NUM_CH independent per-channel checkers.
- Each checker tracks every burst cycle by cycle and raises per-rule error pulses and sticky flags.
- Also counts completed transfers; sits beside the bus in both silicon and simulation.

---
 rtl/bus_mon_pkg.sv | 31 +++
 rtl/bus_handshake_monitor_if.sv | 20 ++
 rtl/bus_handshake_chan_mon.sv | 146 ++++++++++++++
 rtl/bus_handshake_monitor.sv | 114 +++++++++++
 4 files changed

// File: rtl/bus_mon_pkg.sv
// ----------------------------------------------------------------------------
// bus_mon_pkg
// Shared types and constants for the dValid/dAck/data handshake monitor.
//   mon_state_t : per-channel checker state
//   ERR_*       : bit positions inside each channel's 6-bit error vector
//   len_width() : width of the per-burst length counter
// Optional feature macro used elsewhere in this slice: BUS_MON_REPORT_EN.
// ----------------------------------------------------------------------------
package bus_mon_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2,
        ERR    = 2'd3
    } mon_state_t;

    localparam int unsigned ERR_ACK_EARLY = 0;
    localparam int unsigned ERR_DROP      = 1;
    localparam int unsigned ERR_TIMEOUT   = 2;
    localparam int unsigned ERR_HOLD      = 3;
    localparam int unsigned ERR_DATA_CHG  = 4;
    localparam int unsigned ERR_SPUR_ACK  = 5;
    localparam int unsigned NUM_ERR       = 6;

    // Length counter must represent 0..max_valid inclusive.
    function automatic int unsigned len_width(input int unsigned max_valid);
        return (max_valid < 1) ? 1 : $clog2(max_valid + 1);
    endfunction

endpackage

// File: rtl/bus_handshake_monitor_if.sv
// ----------------------------------------------------------------------------
// bus_handshake_monitor_if
// Bundles the per-channel handshake signals of NUM_CH channels.
//   dValid [NUM_CH]        : data valid, driven by the source
//   dAck   [NUM_CH]        : acknowledge, driven by the target
//   data   [NUM_CH*DATA_W] : channel c at [c*DATA_W +: DATA_W]
// Modports: master (source), slave (target), monitor (observe only).
// ----------------------------------------------------------------------------
interface bus_handshake_monitor_if #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned DATA_W = 8
);
    logic [NUM_CH-1:0]        dValid;
    logic [NUM_CH-1:0]        dAck;
    logic [NUM_CH*DATA_W-1:0] data;

    modport master  (output dValid, output data, input dAck);
    modport slave   (input dValid, input data, output dAck);
    modport monitor (input dValid, input dAck, input data);
endinterface

// File: rtl/bus_handshake_chan_mon.sv
// ----------------------------------------------------------------------------
// bus_handshake_chan_mon
// Protocol checker for one dValid/dAck/data channel.
//   i_clk, i_reset  : clock, asynchronous active-high reset
//   i_clr           : synchronous clear of sticky errors
//   i_valid, i_ack  : channel handshake
//   i_data          : channel data (must stay stable during a burst)
//   o_err_pulse     : registered one-cycle error strobes (ERR_* bit order)
//   o_err_sticky    : accumulated strobes, cleared by i_clr
//   o_done          : combinational strobe, high on the edge that closes a
//                     good transfer (counted by the parent on that edge)
// ----------------------------------------------------------------------------
module bus_handshake_chan_mon
    import bus_mon_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MIN_VALID = 2,
    parameter int unsigned MAX_VALID = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_clr,
    input  logic               i_valid,
    input  logic               i_ack,
    input  logic [DATA_W-1:0]  i_data,
    output logic [NUM_ERR-1:0] o_err_pulse,
    output logic [NUM_ERR-1:0] o_err_sticky,
    output logic               o_done
);
    localparam int unsigned LEN_W = len_width(MAX_VALID);
    localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_VALID);
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_VALID);

    mon_state_t         r_state, w_state_nxt;
    logic [LEN_W-1:0]   r_len, w_len_nxt, w_len_cur;
    logic [DATA_W-1:0]  r_data, w_data_nxt;
    logic               r_dchg, w_dchg_nxt;
    logic [NUM_ERR-1:0] r_pulse, w_pulse;
    logic [NUM_ERR-1:0] r_sticky, w_sticky_nxt;
    logic               w_done;

    // Length including the edge currently being evaluated.
    assign w_len_cur = r_len + LEN_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_data_nxt  = r_data;
        w_dchg_nxt  = r_dchg;
        w_pulse     = '0;
        w_done      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_valid) begin
                    w_len_nxt   = LEN_W'(1);
                    w_data_nxt  = i_data;
                    w_dchg_nxt  = 1'b0;
                    w_state_nxt = ACTIVE;
                    if (i_ack) begin
                        if (MIN_VALID > 1) begin
                            w_pulse[ERR_ACK_EARLY] = 1'b1;
                            w_state_nxt            = ERR;
                        end else begin
                            w_state_nxt = DONE;
                        end
                    end
                end else if (i_ack) begin
                    w_pulse[ERR_SPUR_ACK] = 1'b1;
                end
            end
            ACTIVE: begin
                if (!i_valid) begin
                    w_pulse[ERR_DROP] = 1'b1;
                    w_state_nxt       = IDLE;
                end else begin
                    // Report a data change once per burst, but keep checking.
                    if ((i_data != r_data) && !r_dchg) begin
                        w_pulse[ERR_DATA_CHG] = 1'b1;
                        w_dchg_nxt            = 1'b1;
                    end
                    w_len_nxt = w_len_cur;
                    if (i_ack) begin
                        if (w_len_cur < MIN_L) begin
                            w_pulse[ERR_ACK_EARLY] = 1'b1;
                            w_state_nxt            = ERR;
                        end else begin
                            w_state_nxt = DONE;
                        end
                    end else if (w_len_cur == MAX_L) begin
                        w_pulse[ERR_TIMEOUT] = 1'b1;
                        w_state_nxt          = ERR;
                    end
                end
            end
            DONE: begin
                // dAck must be a single-cycle pulse.
                if (i_ack) begin
                    w_pulse[ERR_SPUR_ACK] = 1'b1;
                end
                if (i_valid) begin
                    w_pulse[ERR_HOLD] = 1'b1;
                    w_state_nxt       = ERR;
                end else begin
                    w_done      = !i_ack;
                    w_state_nxt = IDLE;
                end
            end
            ERR: begin
                if (!i_valid) begin
                    w_state_nxt = IDLE;
                    if (i_ack) begin
                        w_pulse[ERR_SPUR_ACK] = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // A strobe coinciding with clr is dropped from the sticky set.
    assign w_sticky_nxt = i_clr ? '0 : (r_sticky | w_pulse);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= IDLE;
            r_len    <= '0;
            r_data   <= '0;
            r_dchg   <= 1'b0;
            r_pulse  <= '0;
            r_sticky <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_len    <= w_len_nxt;
            r_data   <= w_data_nxt;
            r_dchg   <= w_dchg_nxt;
            r_pulse  <= w_pulse;
            r_sticky <= w_sticky_nxt;
        end
    end

    assign o_err_pulse  = r_pulse;
    assign o_err_sticky = r_sticky;
    assign o_done       = w_done;
endmodule

// File: rtl/bus_handshake_monitor.sv
// ----------------------------------------------------------------------------
// bus_handshake_monitor
// Run-time monitor for NUM_CH independent dValid/dAck/data channels.
//   clk, reset  : clock, asynchronous active-high reset
//   clr         : synchronous clear of err_sticky and xfer_cnt
//   bus         : monitored handshake signals (monitor modport)
//   err_pulse   : one-cycle error strobes, channel c at [c*6 +: 6]
//   err_sticky  : accumulated err_pulse, cleared by clr
//   err_any     : OR of all err_sticky bits
//   xfer_cnt    : saturating count of good transfers over all channels
// Macro BUS_MON_REPORT_EN adds simulation-only text reports.
// ----------------------------------------------------------------------------
module bus_handshake_monitor
    import bus_mon_pkg::*;
#(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MIN_VALID = 2,
    parameter int unsigned MAX_VALID = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clr,
    bus_handshake_monitor_if.monitor  bus,
    output logic [NUM_CH*NUM_ERR-1:0] err_pulse,
    output logic [NUM_CH*NUM_ERR-1:0] err_sticky,
    output logic                      err_any,
    output logic [CNT_W-1:0]          xfer_cnt
);
    localparam int unsigned POP_W = $clog2(NUM_CH + 1);
    localparam int unsigned SUM_W = CNT_W + POP_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [NUM_CH-1:0]         w_done;
    logic [NUM_CH*NUM_ERR-1:0] w_pulse;
    logic [NUM_CH*NUM_ERR-1:0] w_sticky;
    logic [POP_W-1:0]          w_pop;
    logic [SUM_W-1:0]          w_sum;
    logic [CNT_W-1:0]          r_cnt;

`ifdef BUS_MON_REPORT_EN
    function automatic string err_name(input int unsigned idx);
        case (idx)
            ERR_ACK_EARLY: return "ACK_EARLY";
            ERR_DROP:      return "DROP";
            ERR_TIMEOUT:   return "TIMEOUT";
            ERR_HOLD:      return "HOLD";
            ERR_DATA_CHG:  return "DATA_CHG";
            default:       return "SPUR_ACK";
        endcase
    endfunction
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : gen_chan
        bus_handshake_chan_mon #(
            .DATA_W    (DATA_W),
            .MIN_VALID (MIN_VALID),
            .MAX_VALID (MAX_VALID)
        ) u_chan (
            .i_clk        (clk),
            .i_reset      (reset),
            .i_clr        (clr),
            .i_valid      (bus.dValid[c]),
            .i_ack        (bus.dAck[c]),
            .i_data       (bus.data[c*DATA_W +: DATA_W]),
            .o_err_pulse  (w_pulse[c*NUM_ERR +: NUM_ERR]),
            .o_err_sticky (w_sticky[c*NUM_ERR +: NUM_ERR]),
            .o_done       (w_done[c])
        );

`ifdef BUS_MON_REPORT_EN
        always @(posedge clk) begin
            if (!reset) begin
                for (int unsigned b = 0; b < NUM_ERR; b++) begin
                    if (w_pulse[c*NUM_ERR + b]) begin
                        $display("%0t ch%0d %s FAIL", $stime, c, err_name(b));
                    end
                end
                if (w_done[c]) begin
                    $display("%0t ch%0d xfer OK len=%0d", $stime, c, u_chan.r_len);
                end
            end
        end
`endif
    end

    always_comb begin
        w_pop = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_pop = w_pop + POP_W'(w_done[i]);
        end
    end

    assign w_sum = SUM_W'(r_cnt) + SUM_W'(w_pop);

    // clr wins over a same-cycle increment; the count never wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (w_sum > SUM_W'(CNT_MAX)) begin
            r_cnt <= CNT_MAX;
        end else begin
            r_cnt <= w_sum[CNT_W-1:0];
        end
    end

    assign err_pulse  = w_pulse;
    assign err_sticky = w_sticky;
    assign err_any    = |w_sticky;
    assign xfer_cnt   = r_cnt;
endmodule
